// File: rtl/serial_byte_tx.sv
// serial_byte_tx: one-entry buffered byte-to-serial feeder, MSB first, with a strobe per bit slot.
module serial_byte_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_out,
  output logic              ser_en,
  output logic              frame_done,
  output logic              busy
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int DW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state;
  logic [DATA_W-1:0] hold, shreg;
  logic              hold_full;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              slot_end, last_bit, frame_end, load, advance, full_nxt, shift_nxt;
  always_comb begin
    slot_end  = div_cnt == DW'(CLKS_PER_BIT - 1);
    last_bit  = bit_cnt == BW'(DATA_W - 1);
    frame_end = state == SHIFT && slot_end && last_bit;
    load      = hold_full && (state == IDLE || frame_end);
    advance   = state == SHIFT && slot_end && !last_bit;
    full_nxt  = load ? 1'b0 : (data_valid && data_ready) ? 1'b1 : hold_full;
    shift_nxt = load || (state == SHIFT && !frame_end);
  end
  // data_ready is the registered inverse of hold_full, so a drain edge can never also accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      data_ready <= 1'b1;
      ser_out    <= 1'b0;
      ser_en     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      hold_full  <= full_nxt;
      data_ready <= !full_nxt;
      busy       <= shift_nxt || full_nxt;
      state      <= shift_nxt ? SHIFT : IDLE;
      if (data_valid && data_ready) hold <= data_in;
      if (load) begin
        shreg      <= hold;
        ser_out    <= hold[DATA_W-1];
        ser_en     <= 1'b1;
        frame_done <= DATA_W == 1;
        bit_cnt    <= '0;
        div_cnt    <= '0;
      end else if (advance) begin
        shreg      <= shreg << 1;
        ser_out    <= shreg[DATA_W-2];
        ser_en     <= 1'b1;
        frame_done <= bit_cnt == BW'(DATA_W - 2);
        bit_cnt    <= bit_cnt + 1'b1;
        div_cnt    <= '0;
      end else begin
        ser_en     <= 1'b0;
        frame_done <= 1'b0;
        if (state == SHIFT) div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_byte_tx.sv
// tb_serial_byte_tx: directed checks of serial_byte_tx at one and four clocks per bit.
module tb_serial_byte_tx;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [7:0]  data_in = '0, data4 = '0;
  logic        data_valid = 1'b0, valid4 = 1'b0;
  logic        data_ready, ser_out, ser_en, frame_done, busy;
  logic        ready4, out4, en4, fd4, busy4;
  logic [7:0]  q1 = '0;
  logic [63:0] en_v, out_v, fd_v;
  logic [31:0] en4_v, out4_v, fd4_v;
  int          n_chk = 0, n_pass = 0;

  serial_byte_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_en(ser_en),
    .frame_done(frame_done), .busy(busy));

  serial_byte_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .data_in(data4), .data_valid(valid4),
    .data_ready(ready4), .ser_out(out4), .ser_en(en4),
    .frame_done(fd4), .busy(busy4));

  always #5 clk = ~clk;

  // downstream shift register fed by the fast instance
  always @(posedge clk) if (ser_en) q1 <= {q1[6:0], ser_out};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    en_v   = {en_v[62:0], ser_en};
    out_v  = {out_v[62:0], ser_out};
    fd_v   = {fd_v[62:0], frame_done};
    en4_v  = {en4_v[30:0], en4};
    out4_v = {out4_v[30:0], out4};
    fd4_v  = {fd4_v[30:0], fd4};
  endtask

  task automatic clr();
    en_v = '0; out_v = '0; fd_v = '0; en4_v = '0; out4_v = '0; fd4_v = '0;
  endtask

  initial begin
    clr();
    repeat (3) step();
    check("rst_ready", data_ready, 1);
    check("rst_out", ser_out, 0);
    check("rst_en", ser_en, 0);
    check("rst_fd", frame_done, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    // single byte
    data_in = 8'hA5; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("t1_ready_low", data_ready, 0);
    check("t1_no_en_yet", ser_en, 0);
    check("t1_busy", busy, 1);
    clr();
    repeat (8) step();
    check("t1_en", en_v[7:0], 8'hFF);
    check("t1_bits", out_v[7:0], 8'hA5);
    check("t1_fd", fd_v[7:0], 8'h01);
    step();
    check("t1_en_off", ser_en, 0);
    check("t1_busy_off", busy, 0);
    check("t1_ready_back", data_ready, 1);
    check("t1_out_held", ser_out, 1);
    check("t1_q", q1, 8'hA5);
    // back-to-back
    data_in = 8'h3C; data_valid = 1'b1;
    step();
    check("t2_full", data_ready, 0);
    data_in = 8'hF0;
    clr();
    step();
    check("t2_drain", data_ready, 1);
    step();
    check("t2_acc2", data_ready, 0);
    data_valid = 1'b0;
    repeat (14) step();
    check("t2_en", en_v[15:0], 16'hFFFF);
    check("t2_bits", out_v[15:0], 16'h3CF0);
    check("t2_fd", fd_v[15:0], 16'h0101);
    step();
    check("t2_en_off", ser_en, 0);
    check("t2_q", q1, 8'hF0);
    // four clocks per bit
    data4 = 8'h81; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    clr();
    repeat (32) step();
    check("t3_en", en4_v, 32'h8888_8888);
    check("t3_bits", out4_v, 32'hF000_000F);
    check("t3_fd", fd4_v, 32'h0000_0008);
    step();
    check("t3_en_off", en4, 0);
    check("t3_busy_off", busy4, 0);
    // backpressure
    data_in = 8'h11; data_valid = 1'b1;
    step();
    data_in = 8'h22;
    clr();
    step();
    step();
    check("t4_acc22", data_ready, 0);
    data_in = 8'h33;
    repeat (6) step();
    check("t4_hold", data_ready, 0);
    step();
    check("t4_drain22", data_ready, 1);
    step();
    check("t4_acc33", data_ready, 0);
    data_valid = 1'b0;
    repeat (14) step();
    check("t4_en", en_v[23:0], 24'hFFFFFF);
    check("t4_order", out_v[23:0], 24'h112233);
    check("t4_fd", fd_v[23:0], 24'h010101);
    step();
    check("t4_en_off", ser_en, 0);
    check("t4_busy_off", busy, 0);
    // reset mid-frame
    data_in = 8'hFF; data_valid = 1'b1;
    step();
    data_in = 8'h55;
    step();
    step();
    check("t5_held", data_ready, 0);
    data_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("t5_en", ser_en, 0);
    check("t5_out", ser_out, 0);
    check("t5_ready", data_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_fd", frame_done, 0);
    step();
    reset_n = 1'b1;
    clr();
    repeat (20) step();
    check("t5_quiet", en_v, 64'h0);
    check("t5_idle", busy, 0);
    data_in = 8'h0F; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    clr();
    repeat (8) step();
    check("t5_new_en", en_v[7:0], 8'hFF);
    check("t5_new_bits", out_v[7:0], 8'h0F);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_byte_tx.md
Name: serial_byte_tx

Overview:
Parallel-to-serial feeder that sits directly upstream of the 8-bit serial-in shift register (`shift_reg`).
- Accepts bytes over a valid/ready handshake into a one-entry holding buffer.
- Shifts each byte out MSB-first on `ser_out`, with a one-cycle `ser_en` strobe per bit.
- `ser_out`/`ser_en` connect directly to the shift register's `in`/`en` ports.
- With `CLKS_PER_BIT`=1, successive bytes stream with no gap cycles.

Parameters:
DATA_W, 8, byte width; bits shifted per frame.
CLKS_PER_BIT, 1, clock cycles per bit slot (>=1); `ser_en` pulses once per slot.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
data_in  input  DATA_W  byte to transmit.
data_valid  input  1  `data_in` valid.
data_ready  output  1  holding buffer empty; byte accepted when `data_valid` && `data_ready` at a clk edge.
ser_out  output  1  current serial bit, MSB first; held stable for the whole bit slot.
ser_en  output  1  one-cycle strobe marking the sample cycle of each bit; drives downstream `en`.
frame_done  output  1  high in the same cycle as the `ser_en` of the last (LSB) bit.
busy  output  1  high while shifting or while the holding buffer is full.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State returns to IDLE; holding buffer empty.
  - Shifter, bit counter and divider counter cleared.
  - Outputs: `data_ready`=1, `ser_out`=0, `ser_en`=0, `frame_done`=0, `busy`=0.
  - Reset mid-frame discards both the partial frame and any held byte; nothing resumes after release.
- All outputs are registered; `data_ready` = !hold_full.
- Holding buffer:
  - On an accept edge, `data_in` is captured and hold_full is set.
  - `data_valid` while `data_ready`=0 is ignored; the upstream block must hold its data.
- States: IDLE, SHIFT.
- IDLE:
  - If hold_full at an edge: load the shifter from the buffer, clear hold_full, go to SHIFT.
  - On that same edge, drive `ser_out` = bit DATA_W-1 and `ser_en`=1; clear bit_cnt and div_cnt.
  - Latency: accept at edge E0, first `ser_en` visible after E1, i.e. 2 cycles from accept.
- SHIFT:
  - div_cnt counts 0..CLKS_PER_BIT-1.
  - `ser_en`=1 only in the cycle where div_cnt==0; `ser_out` holds the current bit for all CLKS_PER_BIT cycles.
  - When div_cnt reaches CLKS_PER_BIT-1, advance to the next bit (bit_cnt+1) and wrap div_cnt to 0.
  - `frame_done`=1 exactly when `ser_en`=1 and bit_cnt==DATA_W-1.
- End of frame (edge ending the last slot):
  - If hold_full: load the next byte and emit its MSB with `ser_en`=1 in the following cycle. Stay in SHIFT with zero gap.
  - Else: go to IDLE with `ser_en`=0; `ser_out` keeps its last value.
- Simultaneous events: the buffer drains into the shifter on the same edge it could be refilled. Because `data_ready` is registered (0 in that cycle), no byte is lost or double-captured. `data_ready` reasserts the cycle after the drain.
- A frame emits exactly DATA_W `ser_en` pulses.
- `busy` = (state==SHIFT) || hold_full.
- Counter widths: bit_cnt is clog2(DATA_W) bits; div_cnt is max(1, clog2(CLKS_PER_BIT)) bits.

Test Plan:
1. Single byte, CLKS_PER_BIT=1:
   - Stimulus: reset, then send 0xA5.
   - Required: `ser_en` high for 8 consecutive cycles starting 2 cycles after accept; `ser_out` = 1,0,1,0,0,1,0,1.
   - Required: `frame_done` only on the 8th pulse; downstream shift_reg q=0xA5; then `busy`=0.
2. Back-to-back, CLKS_PER_BIT=1:
   - Stimulus: 0x3C then 0xF0, `data_valid` held high.
   - Required: 16 contiguous `ser_en` cycles with no gap; `frame_done` on pulse 8 and pulse 16.
   - Required: second accept occurs the cycle after the first byte drains into the shifter.
3. CLKS_PER_BIT=4:
   - Stimulus: send 0x81.
   - Required: `ser_en` pulses every 4th cycle (8 pulses over 32 cycles); `ser_out` stable for 4 cycles per bit.
   - Required: sampled bits are 1,0,0,0,0,0,0,1.
4. Backpressure:
   - Stimulus: while 0x11 shifts and 0x22 is held, present 0x33.
   - Required: `data_ready`=0, 0x33 not captured; it is accepted only after 0x22 drains.
   - Required: output order is 0x11, 0x22, 0x33.
5. Reset mid-frame:
   - Stimulus: assert reset_n=0 after the 3rd bit of 0xFF, with 0x55 held in the buffer.
   - Required: outputs go to reset values immediately (asynchronous).
   - Required: no further `ser_en` after release until a new byte is accepted; 0x55 is never sent.
